memory_game_ctrl: RTL

Sequencing controller for the memory game datapath. Steps a read pointer through the 10-entry pattern ROM, captures the player's 4-bit switch guess on each debounced press of btn0, and compares it with the ROM word. It drives the correct/incorrect LEDs, keeps score and a miss budget, and ends each game in a win or lose state. It sits between the board I/O (sw, btn0, led0, led1) and the existing pattern memory. It replaces ad-hoc compare logic with an explicit FSM.

---
 rtl/memory_game_pkg.sv | 20 ++
 rtl/memory_game_btn_debounce.sv | 54 +++++
 rtl/memory_game_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game controller: FSM encoding and
// default parameter values used by the top level and the bench.
package memory_game_pkg;

  localparam int DEPTH_DEF      = 10;
  localparam int DATA_W_DEF     = 4;
  localparam int MAX_MISSES_DEF = 3;
  localparam int LED_HOLD_DEF   = 4;
  localparam int DEB_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_SHOW_OK  = 3'd2,
    ST_SHOW_BAD = 3'd3,
    ST_WIN      = 3'd4,
    ST_LOSE     = 3'd5
  } state_e;

endpackage

// File: rtl/memory_game_btn_debounce.sv
// Button conditioning: two-flop synchronizer, counting debouncer and a
// one-cycle pulse on each 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [19:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  // The level only flips after DEB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
    press_d = level_d & ~level_q;
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game sequencing controller: walks the pattern ROM, captures a guess
// on each debounced press, compares, shows the result on the LEDs and tracks
// score and misses until the game is won or lost.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_MISSES = MAX_MISSES_DEF,
  parameter int LED_HOLD   = LED_HOLD_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn0,
  output logic [3:0]        rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              led0,
  output logic              led1,
  output logic [3:0]        score,
  output logic              done,
  output logic              fail,
  output state_e            dbg_state
);

  // Score is a 4-bit output, so a 16-entry game saturates it at 15.
  localparam logic [3:0]  SCORE_MAX = (DEPTH > 15) ? 4'd15 : 4'(DEPTH);
  localparam logic [3:0]  MISS_MAX  = 4'(MAX_MISSES);
  localparam logic [3:0]  PTR_LAST  = 4'(DEPTH - 1);
  localparam logic [15:0] HOLD_LAST = 16'(LED_HOLD - 1);

  state_e              state_q, state_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [3:0]          score_q, score_d;
  logic [3:0]          miss_q, miss_d;
  logic [15:0]         hold_q, hold_d;
  logic [DATA_W-1:0]   guess_q, guess_d;
  logic                press;
  logic                hold_last;
  logic                match;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn0),
    .press_o (press)
  );

  assign hold_last = (hold_q == HOLD_LAST);
  assign match     = (guess_q == rom_data);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT;
    else     state_q <= state_d;
  end

  // Next-state logic; presses outside WAIT/WIN/LOSE are simply ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:     if (press) state_d = ST_CHECK;
      ST_CHECK:    state_d = match ? ST_SHOW_OK : ST_SHOW_BAD;
      ST_SHOW_OK:  if (hold_last) state_d = (ptr_q == PTR_LAST) ? ST_WIN : ST_WAIT;
      ST_SHOW_BAD: if (hold_last) state_d = (miss_q == MISS_MAX) ? ST_LOSE : ST_WAIT;
      ST_WIN:      if (press) state_d = ST_WAIT;
      ST_LOSE:     if (press) state_d = ST_WAIT;
      default:     state_d = ST_WAIT;
    endcase
  end

  // Datapath next values: guess capture, counters, pointer and hold timer.
  always_comb begin
    ptr_d   = ptr_q;
    score_d = score_q;
    miss_d  = miss_q;
    hold_d  = hold_q;
    guess_d = guess_q;
    case (state_q)
      ST_WAIT: begin
        if (press) guess_d = sw;
      end
      ST_CHECK: begin
        hold_d = '0;
        if (match) begin
          if (score_q != SCORE_MAX) score_d = score_q + 4'd1;
        end else begin
          if (miss_q != MISS_MAX) miss_d = miss_q + 4'd1;
        end
      end
      ST_SHOW_OK: begin
        if (hold_last) begin
          hold_d = '0;
          // Advance only after the LED window so the ROM has a cycle to settle.
          if (ptr_q != PTR_LAST) ptr_d = ptr_q + 4'd1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      ST_SHOW_BAD: begin
        hold_d = hold_last ? 16'd0 : hold_q + 16'd1;
      end
      ST_WIN, ST_LOSE: begin
        if (press) begin
          ptr_d   = '0;
          score_d = '0;
          miss_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      hold_q  <= '0;
      guess_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      hold_q  <= hold_d;
      guess_q <= guess_d;
    end
  end

  // Outputs decoded from state; the two LED sets are disjoint by construction.
  always_comb begin
    led0      = (state_q == ST_SHOW_OK)  || (state_q == ST_WIN);
    led1      = (state_q == ST_SHOW_BAD) || (state_q == ST_LOSE);
    done      = (state_q == ST_WIN);
    fail      = (state_q == ST_LOSE);
    rom_addr  = ptr_q;
    score     = score_q;
    dbg_state = state_q;
  end

endmodule
